// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, per-frame parity and stop-length codes, and the parity helper.
package uart_pkg;

  // FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // cfg_parity codes
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // cfg_stop codes (2'b11 also selects two stop bits)
  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Parity bit from the mode and the XOR-reduction of the data word.
  function automatic logic parity_of(input logic [1:0] mode, input logic data_xor);
    logic p;
    case (mode)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter. Accepts a word on a valid/ready
// handshake and shifts it out LSB-first as start, data, optional parity and
// 1 / 1.5 / 2 stop bits, paced by the baud oversampling tick.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_tick            oversampling enable, OS_TICK pulses per bit
//   tx_valid/tx_ready word handshake; tx_ready high only in IDLE
//   tx_data           word to send (D_BIT bits)
//   cfg_parity        00 none, 01 even, 10 odd, 11 mark
//   cfg_stop          00 one, 01 one-and-a-half, 1x two stop bits
//   tx_out            registered serial line, idles high
//   tx_busy           frame in progress
//   tx_done_tick      one-clk pulse when the last stop tick completes
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned D_BIT   = 8,
  parameter int unsigned OS_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [D_BIT-1:0] tx_data,
  input  logic [1:0]       cfg_parity,
  input  logic [1:0]       cfg_stop,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int unsigned TW = $clog2(2 * OS_TICK);
  localparam int unsigned IW = $clog2(D_BIT);
  localparam logic [TW-1:0] T_BIT  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] T_1P5  = TW'((3 * OS_TICK) / 2 - 1);
  localparam logic [TW-1:0] T_2    = TW'(2 * OS_TICK - 1);
  localparam logic [IW-1:0] I_LAST = IW'(D_BIT - 1);

  // Reject unsupported frame geometry at elaboration.
  if (D_BIT < 5 || D_BIT > 9 || OS_TICK < 4 || (OS_TICK % 2) != 0) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameters D_BIT=%0d OS_TICK=%0d", D_BIT, OS_TICK);
  end

  logic [2:0]       state_q, state_n;
  logic [TW-1:0]    cnt_q, cnt_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [D_BIT-1:0] shreg_q, shreg_n;
  logic             par_q, par_n;
  logic [1:0]       cpar_q, cpar_n;
  logic [1:0]       cstop_q, cstop_n;
  logic [TW-1:0]    stop_last;
  logic             line_c;
  logic             done_c;

  // State and holding registers; outputs follow one clk behind the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      cpar_q       <= PAR_NONE;
      cstop_q      <= STOP_1;
      tx_out       <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_ready     <= 1'b1;
      tx_busy      <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      shreg_q      <= shreg_n;
      par_q        <= par_n;
      cpar_q       <= cpar_n;
      cstop_q      <= cstop_n;
      tx_out       <= line_c;
      tx_done_tick <= done_c;
      tx_ready     <= (state_n == IDLE);
      tx_busy      <= (state_n != IDLE);
    end
  end

  // Next-state, tick counting and line level.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    par_n   = par_q;
    cpar_n  = cpar_q;
    cstop_n = cstop_q;
    done_c  = 1'b0;
    line_c  = 1'b1;

    case (cstop_q)
      STOP_1:        stop_last = T_BIT;
      STOP_1P5:      stop_last = T_1P5;
      STOP_2, 2'b11: stop_last = T_2;
      default:       stop_last = T_2;
    endcase

    case (state_q)
      IDLE: begin
        // Latch the word and its config; a tick on this edge is not counted.
        if (tx_valid) begin
          shreg_n = tx_data;
          par_n   = parity_of(cfg_parity, ^tx_data);
          cpar_n  = cfg_parity;
          cstop_n = cfg_stop;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        line_c = 1'b0;
        if (s_tick) begin
          if (cnt_q == T_BIT) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = DATA;
          end else begin
            cnt_n = cnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        line_c = shreg_q[0];
        if (s_tick) begin
          if (cnt_q == T_BIT) begin
            cnt_n   = '0;
            shreg_n = shreg_q >> 1;
            if (idx_q == I_LAST) begin
              state_n = (cpar_q != PAR_NONE) ? PARITY : STOP;
            end else begin
              idx_n = idx_q + IW'(1);
            end
          end else begin
            cnt_n = cnt_q + TW'(1);
          end
        end
      end
      PARITY: begin
        line_c = par_q;
        if (s_tick) begin
          if (cnt_q == T_BIT) begin
            cnt_n   = '0;
            state_n = STOP;
          end else begin
            cnt_n = cnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        line_c = 1'b1;
        if (s_tick) begin
          if (cnt_q == stop_last) begin
            cnt_n   = '0;
            done_c  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It is the next generation of the team's fixed 8N1 transmitter. It accepts a word over a valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop bits, paced by the shared baud oversampling tick. It sits between the TX FIFO read side and the tx pin. Parity mode and stop length are selectable per frame.

Parameters:
D_BIT, 8, data bits per frame; legal range 5..9.
OS_TICK, 16, s_tick pulses per bit period; must be even and at least 4.

Ports:
clk  in  1  system clock.
rst  in  1  reset: synchronous, active-high.
s_tick  in  1  oversampling enable from the baud generator; one clk wide.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a word; high exactly when the FSM is in IDLE.
tx_data  in  D_BIT  word to transmit.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1).
cfg_stop  in  2  00 one stop bit, 01 1.5 stop bits, 10 or 11 two stop bits.
tx_out  out  1  serial line, registered; idles high.
tx_busy  out  1  high when the FSM is not in IDLE.
tx_done_tick  out  1  one-clk pulse when the final stop tick of a frame completes.

Behaviour:
- Clock and reset:
  - Single clock, clk. rst is synchronous and active-high.
  - At the first clk edge with rst=1: state=IDLE, tx_out=1, tx_done_tick=0, tx_busy=0, tx_ready=1, all counters 0.
- Accept:
  - A word is accepted on a clk edge where tx_valid && tx_ready.
  - On acceptance: tx_data, cfg_parity and cfg_stop are latched into holding registers, the parity bit is computed from tx_data (even: ^data; odd: ~^data; mark: 1), and the state moves to START.
  - Input changes after acceptance have no effect on the current frame.
- Latency: tx_out goes low on the clk edge following acceptance.
- Tick counter:
  - Width is $clog2(2*OS_TICK).
  - Cleared on acceptance and at every bit boundary.
  - Increments only on cycles where s_tick=1.
  - An s_tick coinciding with the acceptance edge is not counted.
- States:
  - IDLE: tx_out=1.
  - START: tx_out=0 for OS_TICK ticks, then go to DATA with the bit index at 0.
  - DATA: tx_out = shift register bit 0. Each bit lasts OS_TICK ticks, after which the register shifts right. After bit D_BIT-1, go to PARITY if cfg_parity != 00, otherwise go to STOP.
  - PARITY: tx_out = parity bit for OS_TICK ticks, then go to STOP.
  - STOP: tx_out=1 for OS_TICK, 3*OS_TICK/2 or 2*OS_TICK ticks, selected by the latched cfg_stop.
- End of frame:
  - On the s_tick that completes the last stop tick, tx_done_tick=1 for exactly that clk and the next state is IDLE.
  - tx_ready rises on the following edge.
  - Back-to-back frames: a tx_valid held high is accepted in the first IDLE cycle. The next start bit therefore begins 2 clks after the done pulse, and the line stays high for at least those 2 clks.
- Reset mid-frame: rst returns the block to IDLE with tx_out=1 on that edge. No tx_done_tick is generated and the partial frame is dropped.
- tx_done_tick never asserts in any cycle other than STOP completion.
- Illegal parameters (D_BIT outside 5..9, OS_TICK odd or below 4) trigger an elaboration-time $error.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity codes PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK;
  - stop codes STOP_1, STOP_1P5, STOP_2.
- No sub-module is required. Parity is a single reduction held in one register, and the tick counter lives inline.

Test Plan:
1. Plain 8N1. D_BIT=8, OS_TICK=16, s_tick every 4 clks, cfg 00/00, tx_data=0x55 -> tx_out sequence 0,1,0,1,0,1,0,1,0,1. Each bit is exactly 64 clks. tx_done_tick pulses once, 640 clks after the start edge.
2. Even parity. cfg_parity=01, tx_data=0x07 -> parity bit 1, frame is 11 bits long. Odd parity with the same data -> parity bit 0. Mark parity -> parity bit 1.
3. Stop length. cfg_stop=01 -> stop high for 24 ticks; cfg_stop=10 -> stop high for 32 ticks, measured from the end of the last data or parity bit to the done pulse.
4. Back-to-back. tx_valid held high with data 0xA3 then 0x3C -> two complete frames. The second start bit falls 2 clks after the first done pulse. tx_ready is high for exactly 1 clk between the frames.
5. Reset mid-frame. rst=1 during data bit 3 -> tx_out=1 and tx_ready=1 on the next edge, no tx_done_tick. A fresh frame (0xF0) after reset transmits correctly.
6. Config stability and width variants. cfg_parity and tx_data are toggled mid-frame -> the frame still uses the latched values. Re-run with D_BIT=5 (tx_data=0x1B) and D_BIT=9 (tx_data=0x1AB) -> correct bit counts and LSB-first order.
